// File: rtl/sl_pkg.sv
// Shared request/response bus types for the sl_* tree cells.
package sl_pkg;

  localparam int unsigned SL_ADDR_W = 32;
  localparam int unsigned SL_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [SL_ADDR_W-1:0] addr;
    logic [SL_DATA_W-1:0] wdata;
  } SL_REQ;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [SL_DATA_W-1:0] rdata;
  } SL_RES;

  // Response returned on behalf of a child index that does not exist.
  function automatic SL_RES sl_err_res();
    SL_RES res;
    res       = '0;
    res.valid = 1'b1;
    res.err   = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/sl_pipe.sv
// Type-generic register chain; Depth 0 degenerates to a wire.
module sl_pipe #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  T     d_i,
  output T     q_o
);

  if (Depth == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o            = d_i;
  end else begin : g_regs
    T stage_d [Depth];
    T stage_q [Depth];

    always_comb begin
      stage_d[0] = d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // rst_n is active high in this codebase.
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (rst_n) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/sl_n1_cell.sv
// 1-to-N address-decoding tree cell: routes parent requests to one child and
// returns the child's fixed-latency response in order.
module sl_n1_cell
  import sl_pkg::*;
#(
  parameter int unsigned NUM_DOWN  = 4,
  parameter int unsigned INDI      = 12,
  parameter int unsigned DOWN_PIPE = 2,
  parameter int unsigned UP_PIPE   = 1,
  parameter int unsigned CHILD_LAT = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  SL_REQ req_up,
  output SL_RES res_up,
  output SL_REQ req_down [NUM_DOWN],
  input  SL_RES res_down [NUM_DOWN],
  output logic  spurious
);

  localparam int unsigned SEL_W = $clog2(NUM_DOWN);
  localparam int unsigned CNT_W = $clog2(CHILD_LAT + 1);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [SEL_W-1:0] sel;
  } tag_t;

  SL_REQ            req_pipe;
  SL_RES            res_sel;
  SL_RES            res_pipe;
  tag_t             tag_in;
  tag_t             tag_out;
  logic [SEL_W-1:0] sel;
  logic             sel_err;
  logic             spur_hit;
  logic             spurious_d, spurious_q;
  logic [CNT_W-1:0] mask_d, mask_q;

  sl_pipe #(
    .T     (SL_REQ),
    .Depth (DOWN_PIPE)
  ) u_req_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (req_up),
    .q_o   (req_pipe)
  );

  assign sel     = req_pipe.addr[INDI +: SEL_W];
  assign sel_err = 32'(sel) >= NUM_DOWN;

  // Payload is broadcast; only the addressed child sees valid.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DOWN; i++) begin
      req_down[i]       = req_pipe;
      req_down[i].valid = req_pipe.valid && (32'(sel) == i);
      if (rst_n) begin
        req_down[i] = '0;
      end
    end
  end

  always_comb begin
    tag_in = '0;
    if (req_pipe.valid && !rst_n) begin
      tag_in.valid = 1'b1;
      tag_in.err   = sel_err;
      tag_in.sel   = sel;
    end
  end

  sl_pipe #(
    .T     (tag_t),
    .Depth (CHILD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (tag_in),
    .q_o   (tag_out)
  );

  // Any child response not claimed by the exiting tag is dropped and flagged.
  always_comb begin
    res_sel  = '0;
    spur_hit = 1'b0;
    if (tag_out.valid && tag_out.err) begin
      res_sel = sl_err_res();
    end
    for (int unsigned i = 0; i < NUM_DOWN; i++) begin
      if (tag_out.valid && !tag_out.err && (32'(tag_out.sel) == i)) begin
        res_sel = res_down[i];
      end else if (res_down[i].valid) begin
        spur_hit = 1'b1;
      end
    end
  end

  sl_pipe #(
    .T     (SL_RES),
    .Depth (UP_PIPE)
  ) u_res_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (res_sel),
    .q_o   (res_pipe)
  );

  assign res_up = rst_n ? '0 : res_pipe;

  // Children may still answer requests issued before reset; ignore them for
  // CHILD_LAT cycles after reset releases.
  always_comb begin
    mask_d     = (mask_q != '0) ? mask_q - CNT_W'(1) : mask_q;
    spurious_d = spurious_q || (spur_hit && (mask_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      spurious_q <= 1'b0;
      mask_q     <= CNT_W'(CHILD_LAT);
    end else begin
      spurious_q <= spurious_d;
      mask_q     <= mask_d;
    end
  end

  assign spurious = spurious_q;

endmodule
